universal_shift_reg: RTL and testbench

//  Parametrised universal register; successor to the basic clear/load/enable register.

---
 rtl/universal_shift_reg.sv | 152 +++++++++++++++
 tb/tb_universal_shift_reg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal register: parallel load, serial shift/rotate bursts with busy/done handshake.
// Define USR_COUNT_EN to enable the inc/dec ops (110/111) and the carry flag.
module universal_shift_reg #(
   parameter int LEN   = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             clk_enable,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic             abort,
   input  logic [LEN-1:0]   data,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [LEN-1:0]   q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done,
   output logic             carry
);

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_LOAD = 3'b001,
      OP_SHL  = 3'b010,
      OP_SHR  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101,
      OP_INC  = 3'b110,
      OP_DEC  = 3'b111
   } op_t;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   typedef struct packed {
      op_t              op;
      logic [AMT_W-1:0] remaining;
   } burst_t;

   state_t         state, state_nxt;
   burst_t         burst, burst_nxt;
   logic [LEN-1:0] q_r, q_nxt;
   logic           done_r, done_nxt;
   op_t            cmd;

   assign cmd = op_t'(op);

   function automatic logic [LEN-1:0] step(input op_t o, input logic [LEN-1:0] v,
                                           input logic sr, input logic sl);
      case (o)
         OP_SHL:  step = {v[LEN-2:0], sr};
         OP_SHR:  step = {sl, v[LEN-1:1]};
         OP_ROL:  step = {v[LEN-2:0], v[LEN-1]};
         OP_ROR:  step = {v[0], v[LEN-1:1]};
         default: step = v;
      endcase
   endfunction

`ifdef USR_COUNT_EN
   logic carry_r, carry_nxt;
`endif

   always_comb begin
      q_nxt     = q_r;
      state_nxt = state;
      burst_nxt = burst;
      done_nxt  = 1'b0;
`ifdef USR_COUNT_EN
      carry_nxt = carry_r;
`endif
      if (clk_enable) begin
         case (state)
            IDLE: begin
               if (start) begin
                  done_nxt = 1'b1;
                  case (cmd)
                     OP_LOAD: q_nxt = data;
`ifdef USR_COUNT_EN
                     OP_INC:  {carry_nxt, q_nxt} = {1'b0, q_r} + (LEN+1)'(1);
                     OP_DEC:  {carry_nxt, q_nxt} = {1'b0, q_r} - (LEN+1)'(1);
`endif
                     OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                        if (amount != '0)
                           q_nxt = step(cmd, q_r, sin_r, sin_l);
                        // multi-step burst: first step taken now, rest from BUSY
                        if (amount > AMT_W'(1)) begin
                           done_nxt            = 1'b0;
                           state_nxt           = BUSY;
                           burst_nxt.op        = cmd;
                           burst_nxt.remaining = amount - AMT_W'(1);
                        end
                     end
                     default: ;
                  endcase
`ifdef USR_COUNT_EN
                  if (cmd != OP_INC && cmd != OP_DEC)
                     carry_nxt = 1'b0;
`endif
               end
            end
            BUSY: begin
               if (abort) begin
                  state_nxt           = IDLE;
                  burst_nxt.remaining = '0;
               end else begin
                  q_nxt               = step(burst.op, q_r, sin_r, sin_l);
                  burst_nxt.remaining = burst.remaining - AMT_W'(1);
                  if (burst.remaining == AMT_W'(1)) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q_r    <= '0;
         state  <= IDLE;
         burst  <= '0;
         done_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         state  <= state_nxt;
         burst  <= burst_nxt;
         done_r <= done_nxt;
      end
   end

`ifdef USR_COUNT_EN
   always_ff @(posedge clk) begin
      if (clr) carry_r <= 1'b0;
      else     carry_r <= carry_nxt;
   end
   assign carry = carry_r;
`else
   assign carry = 1'b0;
`endif

   assign q      = q_r;
   assign sout_l = q_r[LEN-1];
   assign sout_r = q_r[0];
   assign busy   = (state == BUSY);
   assign done   = done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed scenarios plus random traffic against a
// cycle-level reference model built from integer arithmetic.
module tb_universal_shift_reg;
   localparam int LEN   = 8;
   localparam int AMT_W = 4;
   localparam int MASK  = (1 << LEN) - 1;

   logic             clk = 1'b0;
   logic             clr, clk_enable, start, abort, sin_r, sin_l;
   logic [2:0]       op;
   logic [AMT_W-1:0] amount;
   logic [LEN-1:0]   data;
   logic [LEN-1:0]   q;
   logic             sout_l, sout_r, busy, done, carry;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   universal_shift_reg #(.LEN(LEN), .AMT_W(AMT_W)) dut (
      .clk(clk), .clr(clr), .clk_enable(clk_enable), .start(start), .op(op),
      .amount(amount), .abort(abort), .data(data), .sin_r(sin_r), .sin_l(sin_l),
      .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done), .carry(carry)
   );

   // reference model: register value as an integer, steps remaining in the burst
   int m_q, m_left, m_op;
   bit m_busy, m_done, m_carry;

   function automatic int one_step(int o, int v, bit sr, bit sl);
      case (o)
         2:       return ((v << 1) | int'(sr)) & MASK;
         3:       return (v >> 1) | (int'(sl) << (LEN-1));
         4:       return ((v << 1) | (v >> (LEN-1))) & MASK;
         5:       return (v >> 1) | ((v & 1) << (LEN-1));
         default: return v;
      endcase
   endfunction

   always @(posedge clk) begin
      int o;
      o = int'(op);
      if (clr) begin
         m_q = 0; m_busy = 0; m_done = 0; m_carry = 0; m_left = 0;
      end else begin
         m_done = 0;
         if (clk_enable) begin
            if (!m_busy && start) begin
               if (o >= 2 && o <= 5) begin
                  m_carry = 0;
                  if (amount == 0) m_done = 1;
                  else begin
                     m_q    = one_step(o, m_q, sin_r, sin_l);
                     m_left = int'(amount) - 1;
                     m_op   = o;
                     if (m_left == 0) m_done = 1;
                     else             m_busy = 1;
                  end
               end else begin
                  m_done = 1;
                  if (o == 0) m_carry = 0;
                  if (o == 1) begin m_q = int'(data); m_carry = 0; end
`ifdef USR_COUNT_EN
                  if (o == 6) begin m_carry = (m_q == MASK); m_q = (m_q + 1) & MASK; end
                  if (o == 7) begin m_carry = (m_q == 0);    m_q = (m_q - 1) & MASK; end
`endif
               end
            end else if (m_busy) begin
               if (abort) begin
                  m_busy = 0; m_left = 0;
               end else begin
                  m_q    = one_step(m_op, m_q, sin_r, sin_l);
                  m_left = m_left - 1;
                  if (m_left == 0) begin m_busy = 0; m_done = 1; end
               end
            end
         end
      end
   end

   task automatic cmd(input logic [2:0] o, input int amt, input int d);
      op = o; amount = AMT_W'(amt); data = LEN'(d); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [LEN-1:0] mq;
      clr = 1'b1;
      @(negedge clk); @(negedge clk);
      total++;
      if ({q, busy, done, carry} !== '0) begin
         bad++; $display("FAIL reset_state: got q=%h b=%b d=%b c=%b, want all 0", q, busy, done, carry);
      end
      clr = 1'b0;
      cmd(3'b001, 0, 'hA5);
      cmd(3'b100, 8, 0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      mq = m_q[LEN-1:0];
      total++;
      if ({q, busy, done, carry} !== '0 || mq !== '0) begin
         bad++; $display("FAIL reset_midburst: got q=%h b=%b d=%b c=%b, want all 0", q, busy, done, carry);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_nodone: got b=%b d=%b, want 0 0", busy, done);
         end
      end
   endtask

   task automatic test_shl_burst();
      int bc = 0, dc = 0;
      logic [LEN-1:0] qd = '0;
      cmd(3'b001, 0, 'h81);
      total++;
      if (q !== 8'h81 || done !== 1'b1) begin
         bad++; $display("FAIL load: got q=%h d=%b, want 81 1", q, done);
      end
      sin_r = 1'b1;
      cmd(3'b010, 3, 0);
      for (int i = 1; i <= 6; i++) begin
         if (i > 1) @(negedge clk);
         total++;
         if ({q, busy, done} !== {m_q[LEN-1:0], m_busy, m_done}) begin
            bad++; $display("FAIL shl_model: cyc %0d got q=%h b=%b d=%b, want q=%h b=%b d=%b",
                            i, q, busy, done, m_q[LEN-1:0], m_busy, m_done);
         end
         if (busy) bc++;
         if (done) begin dc++; qd = q; end
      end
      total++;
      if (bc != 2 || dc != 1 || qd !== 8'h0F) begin
         bad++; $display("FAIL shl_burst: busy=%0d done=%0d q=%h, want 2 1 0f", bc, dc, qd);
      end
      sin_r = 1'b0;
   endtask

   task automatic test_ror_wrap();
      int bc = 0, done_at = 0;
      cmd(3'b001, 0, 'h81);
      cmd(3'b101, 9, 0);
      for (int i = 1; i <= 12; i++) begin
         if (i > 1) @(negedge clk);
         if (busy) bc++;
         if (done && done_at == 0) done_at = i;
      end
      total++;
      if (bc != 8 || done_at != 9 || q !== 8'hC0) begin
         bad++; $display("FAIL ror_wrap: busy=%0d done_at=%0d q=%h, want 8 9 c0", bc, done_at, q);
      end
   endtask

   task automatic test_stall_abort();
      int done_at = 0, dc = 0;
      cmd(3'b001, 0, 'hB4);
      sin_l = 1'b0;
      cmd(3'b011, 5, 0);
      for (int i = 1; i <= 10; i++) begin
         if (i > 1) @(negedge clk);
         total++;
         if ({q, busy, done} !== {m_q[LEN-1:0], m_busy, m_done}) begin
            bad++; $display("FAIL stall_model: cyc %0d got q=%h b=%b d=%b, want q=%h b=%b d=%b",
                            i, q, busy, done, m_q[LEN-1:0], m_busy, m_done);
         end
         if (done && done_at == 0) done_at = i;
         clk_enable = !(i == 2 || i == 3);
      end
      clk_enable = 1'b1;
      total++;
      if (done_at != 7 || q !== 8'h05) begin
         bad++; $display("FAIL shr_stall: done_at=%0d q=%h, want 7 05", done_at, q);
      end
      cmd(3'b001, 0, 'hB4);
      sin_l = 1'b1;
      cmd(3'b011, 5, 0);
      for (int i = 1; i <= 6; i++) begin
         if (i > 1) @(negedge clk);
         if (i >= 1 && done) dc++;
         abort = (i == 2);
      end
      total++;
      if (q !== 8'hED || busy !== 1'b0 || dc != 0) begin
         bad++; $display("FAIL shr_abort: q=%h b=%b dones=%0d, want ed 0 0", q, busy, dc);
      end
      abort = 1'b0; sin_l = 1'b0;
   endtask

   task automatic test_count();
      cmd(3'b001, 0, 'hFF);
      cmd(3'b110, 0, 0);
`ifdef USR_COUNT_EN
      total++;
      if (q !== 8'h00 || carry !== 1'b1 || done !== 1'b1) begin
         bad++; $display("FAIL inc_wrap: q=%h c=%b d=%b, want 00 1 1", q, carry, done);
      end
      cmd(3'b111, 0, 0);
      total++;
      if (q !== 8'hFF || carry !== 1'b1) begin
         bad++; $display("FAIL dec_borrow: q=%h c=%b, want ff 1", q, carry);
      end
      cmd(3'b001, 0, 'h3C);
      total++;
      if (q !== 8'h3C || carry !== 1'b0) begin
         bad++; $display("FAIL load_clears_carry: q=%h c=%b, want 3c 0", q, carry);
      end
`else
      total++;
      if (q !== 8'hFF || carry !== 1'b0 || done !== 1'b1) begin
         bad++; $display("FAIL inc_as_hold: q=%h c=%b d=%b, want ff 0 1", q, carry, done);
      end
`endif
   endtask

   task automatic test_amount_zero();
      int bc = 0;
      cmd(3'b001, 0, 'h5A);
      cmd(3'b010, 0, 0);
      total++;
      if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL amt0: q=%h d=%b b=%b, want 5a 1 0", q, done, busy);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (busy || done) bc++;
      end
      total++;
      if (bc != 0) begin
         bad++; $display("FAIL amt0_quiet: busy/done seen %0d times, want 0", bc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         clr        = ($urandom_range(0, 59) == 0);
         clk_enable = ($urandom_range(0, 9) < 8);
         start      = ($urandom_range(0, 2) == 0);
         abort      = ($urandom_range(0, 11) == 0);
         op         = 3'($urandom_range(0, 7));
         amount     = ($urandom_range(0, 3) == 0) ? AMT_W'($urandom_range(0, 15))
                                                  : AMT_W'($urandom_range(0, 3));
         data       = LEN'($urandom);
         sin_r      = 1'($urandom);
         sin_l      = 1'($urandom);
         @(negedge clk);
         total++;
         if ({q, busy, done, carry, sout_l, sout_r} !==
             {m_q[LEN-1:0], m_busy, m_done, m_carry, m_q[LEN-1], m_q[0]}) begin
            bad++; $display("FAIL random: cyc %0d got q=%h b=%b d=%b c=%b sl=%b sr=%b, want q=%h b=%b d=%b c=%b",
                            i, q, busy, done, carry, sout_l, sout_r,
                            m_q[LEN-1:0], m_busy, m_done, m_carry);
         end
      end
      clr = 1'b0; clk_enable = 1'b1; start = 1'b0; abort = 1'b0;
   endtask

   initial begin
      clr = 1'b1; clk_enable = 1'b1; start = 1'b0; abort = 1'b0;
      op = 3'b000; amount = '0; data = '0; sin_r = 1'b0; sin_l = 1'b0;
      test_reset();
      test_shl_burst();
      test_ror_wrap();
      test_stall_abort();
      test_count();
      test_amount_zero();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
